// File: rtl/aes_pkg.sv
// Shared AES byte-substitution definitions.
//   byte_t   : 8-bit byte
//   state_t  : sub_bytes_seq FSM encoding
//   SBOX_FWD : forward S-box, indexed by input byte
//   SBOX_INV : inverse S-box, indexed by input byte
//   clog2    : ceil(log2(v)), 0 for v<=1
package aes_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam byte_t SBOX_FWD [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  localparam byte_t SBOX_INV [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane.
//   din  : input byte
//   inv  : 0 = forward S-box, 1 = inverse S-box
//   dout : substituted byte
module sbox_lane
  import aes_pkg::*;
(
  input  byte_t din,
  input  logic  inv,
  output byte_t dout
);

  assign dout = inv ? SBOX_INV[din] : SBOX_FWD[din];

endmodule

// File: rtl/sub_bytes_seq.sv
// Time-multiplexed AES SubBytes: LANES S-boxes walk an N-byte block over
// BEATS = NUM_BYTES/LANES cycles, rewriting the block register in place.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake; in_data/in_inv captured on accept
//   out_valid/out_ready  : output handshake
//   out_data, out_inv    : substituted block and echoed mode, held while stalled
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int NUM_BYTES = 16,
  parameter int LANES     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_data,
  input  logic                   in_inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data,
  output logic                   out_inv
);

  localparam int BEATS = NUM_BYTES / LANES;
  localparam int BW    = (clog2(BEATS) < 1) ? 1 : clog2(BEATS);

  if (LANES < 1 || NUM_BYTES < 1 || (NUM_BYTES % LANES) != 0) begin : g_bad_cfg
    $error("sub_bytes_seq: LANES must be >=1 and divide NUM_BYTES");
  end

  // Grouped by beat so a beat's bytes are one slice; the flat bit order still
  // matches in_data (byte k lives in beat k/LANES, lane k%LANES).
  byte_t [BEATS-1:0][LANES-1:0] data_q;
  byte_t [LANES-1:0]            lane_out;
  logic  [BW-1:0]               beat;
  logic                         inv_q;
  state_t                       state;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox_lane u_lane (
      .din  (data_q[beat][l]),
      .inv  (inv_q),
      .dout (lane_out[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      data_q    <= '0;
      inv_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          data_q   <= in_data;
          inv_q    <= in_inv;
          beat     <= '0;
          in_ready <= 1'b0;
          state    <= BUSY;
        end
        BUSY: begin
          data_q[beat] <= lane_out;
          if (beat == BW'(BEATS - 1)) begin
            beat      <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = data_q;
  assign out_inv  = inv_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed + randomized-handshake bench for sub_bytes_seq in three shapes:
//   a: NUM_BYTES=16 LANES=4, b: NUM_BYTES=4 LANES=4, c: NUM_BYTES=4 LANES=1.
module tb_sub_bytes_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_iv = 0, a_ir, a_ii = 0, a_ov, a_or = 0, a_oi;
  logic [127:0] a_id = '0, a_od;
  logic         b_iv = 0, b_ir, b_ii = 0, b_ov, b_or = 0, b_oi;
  logic [31:0]  b_id = '0, b_od;
  logic         c_iv = 0, c_ir, c_ii = 0, c_ov, c_or = 0, c_oi;
  logic [31:0]  c_id = '0, c_od;

  int n_pass = 0;
  int n_total = 0;

  // Hand-computed vectors: vin[i] through mode vinv[i] gives vout[i].
  logic [127:0] vin [6];
  logic [127:0] vout[6];
  logic         vinv[6];

  sub_bytes_seq #(.NUM_BYTES(16), .LANES(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_inv(a_ii),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_inv(a_oi));
  sub_bytes_seq #(.NUM_BYTES(4), .LANES(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_inv(b_ii),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_inv(b_oi));
  sub_bytes_seq #(.NUM_BYTES(4), .LANES(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id), .in_inv(c_ii),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_inv(c_oi));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic a_send(input logic [127:0] d, input logic inv);
    int n = 0;
    a_iv = 1; a_id = d; a_ii = inv;
    while (!a_ir && n < 50) begin tick(); n++; end
    tick();
    a_iv = 0;
    n_total++;
    if (n >= 50) $display("FAIL a_send_timeout: waited %0d cycles, required < 50", n);
    else n_pass++;
  endtask

  task automatic a_recv(output logic [127:0] d, output logic inv);
    int n = 0;
    a_or = 1;
    while (!a_ov && n < 50) begin tick(); n++; end
    d = a_od; inv = a_oi;
    tick();
    a_or = 0;
    n_total++;
    if (n >= 50) $display("FAIL a_recv_timeout: waited %0d cycles, required < 50", n);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_total += 8;
    if (a_ir !== 1'b1 || a_ov !== 1'b0) $display("FAIL rst_a_hs: ir=%b ov=%b required 1 0", a_ir, a_ov); else n_pass++;
    if (a_od !== '0 || a_oi !== 1'b0) $display("FAIL rst_a_data: od=%h oi=%b required 0 0", a_od, a_oi); else n_pass++;
    if (b_ir !== 1'b1 || b_ov !== 1'b0) $display("FAIL rst_b_hs: ir=%b ov=%b required 1 0", b_ir, b_ov); else n_pass++;
    if (b_od !== '0 || b_oi !== 1'b0) $display("FAIL rst_b_data: od=%h oi=%b required 0 0", b_od, b_oi); else n_pass++;
    if (c_ir !== 1'b1 || c_ov !== 1'b0) $display("FAIL rst_c_hs: ir=%b ov=%b required 1 0", c_ir, c_ov); else n_pass++;
    if (c_od !== '0 || c_oi !== 1'b0) $display("FAIL rst_c_data: od=%h oi=%b required 0 0", c_od, c_oi); else n_pass++;
    rst = 0;
    tick();
    if (a_ir !== 1'b1) $display("FAIL rst_a_idle: ir=%b required 1", a_ir); else n_pass++;
    if (c_ov !== 1'b0) $display("FAIL rst_c_idle: ov=%b required 0", c_ov); else n_pass++;
  endtask

  task automatic test_fwd_4x4();
    b_iv = 1; b_id = 32'h53020100; b_ii = 0;
    tick();                                   // edge T: accept
    b_iv = 0;
    n_total += 5;
    if (b_ov !== 1'b0 || b_ir !== 1'b0) $display("FAIL b_busy: ov=%b ir=%b required 0 0", b_ov, b_ir); else n_pass++;
    tick();                                   // edge T+1
    if (b_ov !== 1'b1) $display("FAIL b_latency: ov=%b required 1", b_ov); else n_pass++;
    if (b_od !== 32'hED777C63) $display("FAIL b_fwd_data: got %h required ED777C63", b_od); else n_pass++;
    if (b_oi !== 1'b0) $display("FAIL b_fwd_inv: got %b required 0", b_oi); else n_pass++;
    b_or = 1;
    tick();
    b_or = 0;
    if (b_ov !== 1'b0 || b_ir !== 1'b1) $display("FAIL b_release: ov=%b ir=%b required 0 1", b_ov, b_ir); else n_pass++;
  endtask

  task automatic test_inv_4x1();
    c_iv = 1; c_id = 32'hED777C63; c_ii = 1;
    tick();                                   // edge T
    c_iv = 0;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (c_ov !== 1'b0) $display("FAIL c_busy_%0d: ov=%b required 0", k, c_ov); else n_pass++;
      tick();
    end                                       // now after edge T+4
    n_total += 4;
    if (c_ov !== 1'b1) $display("FAIL c_latency: ov=%b required 1", c_ov); else n_pass++;
    if (c_od !== 32'h53020100) $display("FAIL c_inv_data: got %h required 53020100", c_od); else n_pass++;
    if (c_oi !== 1'b1) $display("FAIL c_inv_echo: got %b required 1", c_oi); else n_pass++;
    c_or = 1;
    tick();
    c_or = 0;
    if (c_ir !== 1'b1) $display("FAIL c_release: ir=%b required 1", c_ir); else n_pass++;
  endtask

  task automatic test_round_trip();
    logic [127:0] r, back, blk;
    logic ri, bi;
    a_send(vin[0], 1'b0);
    a_recv(r, ri);
    n_total += 2;
    if (r !== vout[0] || ri !== 1'b0) $display("FAIL rt_fwd: got %h/%b required %h/0", r, ri, vout[0]); else n_pass++;
    a_send(r, 1'b1);
    a_recv(back, bi);
    if (back !== vin[0] || bi !== 1'b1) $display("FAIL rt_inv: got %h/%b required %h/1", back, bi, vin[0]); else n_pass++;
    // Every byte value 0..255 goes forward then back through the engine.
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) blk[8*k +: 8] = 8'(b * 16 + k);
      a_send(blk, 1'b0);
      a_recv(r, ri);
      a_send(r, 1'b1);
      a_recv(back, bi);
      n_total++;
      if (back !== blk || ri !== 1'b0 || bi !== 1'b1)
        $display("FAIL rt_all_%0d: got %h (inv %b,%b) required %h (inv 0,1)", b, back, ri, bi, blk);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    a_send(vin[0], 1'b0);
    while (!a_ov && n < 50) begin tick(); n++; end
    a_iv = 1; a_id = vin[2]; a_ii = vinv[2];  // second block offered during the stall
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if (a_ov !== 1'b1 || a_ir !== 1'b0 || a_od !== vout[0] || a_oi !== 1'b0)
        $display("FAIL bp_hold_%0d: ov=%b ir=%b od=%h oi=%b required 1 0 %h 0", k, a_ov, a_ir, a_od, a_oi, vout[0]);
      else n_pass++;
      tick();
    end
    a_or = 1;
    tick();                                   // edge H: out handshake
    a_or = 0;
    n_total += 3;
    if (a_ir !== 1'b1 || a_ov !== 1'b0) $display("FAIL bp_after_hs: ir=%b ov=%b required 1 0", a_ir, a_ov); else n_pass++;
    tick();                                   // edge H+1: second block accepted
    a_iv = 0;
    if (a_ir !== 1'b0) $display("FAIL bp_accept: ir=%b required 0", a_ir); else n_pass++;
    n = 0;
    a_or = 1;
    while (!a_ov && n < 50) begin tick(); n++; end
    if (a_od !== vout[2] || a_oi !== 1'b1) $display("FAIL bp_second: got %h/%b required %h/1", a_od, a_oi, vout[2]); else n_pass++;
    tick();
    a_or = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    c_iv = 1; c_id = 32'hED777C63; c_ii = 1;
    tick();                                   // edge T: accept
    c_iv = 0;
    tick();                                   // in 2nd BUSY cycle
    rst = 1;
    tick();
    rst = 0;
    n_total += 5;
    if (c_ir !== 1'b1 || c_ov !== 1'b0) $display("FAIL mid_rst_hs: ir=%b ov=%b required 1 0", c_ir, c_ov); else n_pass++;
    if (c_od !== 32'h0 || c_oi !== 1'b0) $display("FAIL mid_rst_data: od=%h oi=%b required 0 0", c_od, c_oi); else n_pass++;
    c_iv = 1; c_id = 32'h53535353; c_ii = 0;
    tick();
    c_iv = 0;
    while (!c_ov && n < 20) begin tick(); n++; end
    if (n !== 4) $display("FAIL mid_rst_latency: %0d cycles required 4", n); else n_pass++;
    if (c_od !== 32'hEDEDEDED) $display("FAIL mid_rst_data2: got %h required EDEDEDED", c_od); else n_pass++;
    if (c_oi !== 1'b0) $display("FAIL mid_rst_inv2: got %b required 0", c_oi); else n_pass++;
    c_or = 1;
    tick();
    c_or = 0;
  endtask

  task automatic test_random();
    int exp_q[$];
    int nblk = 24;
    int got = 0;
    int cyc = 0;
    bit p_to = 0;
    fork
      begin : producer
        for (int i = 0; i < nblk; i++) begin
          int idx, w;
          idx = $urandom_range(0, 5);
          while ($urandom_range(0, 2) == 0) tick();
          a_iv = 1; a_id = vin[idx]; a_ii = vinv[idx];
          w = 0;
          while (!a_ir && w < 200) begin tick(); w++; end
          if (w >= 200) p_to = 1;
          exp_q.push_back(idx);
          tick();
          a_iv = 0;
        end
      end
      begin : consumer
        while (got < nblk && cyc < 5000) begin
          a_or = 1'($urandom_range(0, 1));
          if (a_ov && a_or) begin
            n_total++;
            if (exp_q.size() == 0) $display("FAIL rnd_dup: extra block %h", a_od);
            else begin
              int e;
              e = exp_q.pop_front();
              if (a_od !== vout[e] || a_oi !== vinv[e])
                $display("FAIL rnd_blk_%0d: got %h/%b required %h/%b", got, a_od, a_oi, vout[e], vinv[e]);
              else n_pass++;
            end
            got++;
          end
          tick();
          cyc++;
        end
        a_or = 0;
      end
    join
    n_total += 2;
    if (got !== nblk || p_to) $display("FAIL rnd_count: got %0d blocks (stall %b) required %0d", got, p_to, nblk); else n_pass++;
    if (exp_q.size() !== 0) $display("FAIL rnd_leftover: %0d blocks pending required 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    vin[0] = 128'h00112233445566778899AABBCCDDEEFF; vinv[0] = 0; vout[0] = 128'h638293C31BFC33F5C4EEACEA4BC12816;
    vin[1] = 128'h638293C31BFC33F5C4EEACEA4BC12816; vinv[1] = 1; vout[1] = 128'h00112233445566778899AABBCCDDEEFF;
    vin[2] = '0;             vinv[2] = 1; vout[2] = {16{8'h52}};
    vin[3] = '0;             vinv[3] = 0; vout[3] = {16{8'h63}};
    vin[4] = {16{8'h53}};    vinv[4] = 0; vout[4] = {16{8'hED}};
    vin[5] = {16{8'hED}};    vinv[5] = 1; vout[5] = {16{8'h53}};
    test_reset();
    test_fwd_4x4();
    test_inv_4x1();
    test_round_trip();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
